// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to a PS/2 device: inhibits the clock, issues a
// request-to-send, shifts 8 data bits, odd parity and stop on the
// device-generated clock, then checks the device acknowledge.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 3500,
  parameter int TIMEOUT_CYCLES = 420000,
  parameter int FILTER         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER + 1);

  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER - 1);
  localparam logic [3:0]    BIT_LAST = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQUEST,
    S_SHIFT,
    S_ACK,
    S_WAITIDLE
  } state_t;

  state_t          state_q;
  logic            clk_meta_q, clk_sync_q;
  logic            dat_meta_q, dat_sync_q;
  logic            clk_filt_q, clk_filt_d;
  logic            clk_prev_q;
  logic [FW-1:0]   filt_cnt_q, filt_cnt_d;
  logic [TW-1:0]   timer_q;
  logic [3:0]      bit_cnt_q;
  logic [7:0]      data_q;
  logic            parity_q;
  logic            fall;

  // Two-flop synchronisers for both raw PS/2 lines; idle level is high.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2clk_in;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2data_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Glitch filter: accept a new clock level only after FILTER equal samples.
  // NOTE: defaults assigned first so no path through this block infers a latch.
  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q != clk_filt_q) begin
      if (filt_cnt_q == FLT_LAST) begin
        clk_filt_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  // Filtered clock level, its previous value and the sample counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_filt_q <= 1'b1;
      clk_prev_q <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_filt_q <= clk_filt_d;
      clk_prev_q <= clk_filt_q;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // One-cycle strobe on each filtered 1->0 transition of the PS/2 clock.
  assign fall = clk_prev_q & ~clk_filt_q;

  // Transaction FSM with registered line drivers and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      parity_q   <= 1'b0;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q != S_IDLE && timer_q == TMO_LAST) begin
        // Whole-transaction watchdog: abandon the frame and free the bus.
        state_q    <= S_IDLE;
        ps2clk_oe  <= 1'b0;
        ps2data_oe <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b1;
        error      <= 1'b1;
      end else begin
        if (state_q != S_IDLE) timer_q <= timer_q + 1'b1;
        case (state_q)
          S_IDLE: begin
            // A start coinciding with the done pulse is deferred one cycle.
            if (tx_start && !done) begin
              data_q     <= tx_data;
              parity_q   <= ~^tx_data;
              timer_q    <= '0;
              bit_cnt_q  <= '0;
              busy       <= 1'b1;
              error      <= 1'b0;
              ps2clk_oe  <= 1'b1;
              ps2data_oe <= 1'b0;
              state_q    <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (timer_q == INH_LAST) begin
              ps2clk_oe  <= 1'b0;
              ps2data_oe <= 1'b1;
              bit_cnt_q  <= '0;
              state_q    <= S_REQUEST;
            end
          end
          S_REQUEST: begin
            state_q <= S_SHIFT;
          end
          S_SHIFT: begin
            if (fall) begin
              if (bit_cnt_q != BIT_LAST) bit_cnt_q <= bit_cnt_q + 1'b1;
              // bit_cnt_q holds the edge number minus one.
              case (bit_cnt_q)
                4'd8: ps2data_oe <= ~parity_q;
                4'd9: begin
                  ps2data_oe <= 1'b0;
                  state_q    <= S_ACK;
                end
                default: ps2data_oe <= ~data_q[bit_cnt_q[2:0]];
              endcase
            end
          end
          S_ACK: begin
            if (fall) begin
              bit_cnt_q <= BIT_LAST;
              error     <= dat_sync_q;
              state_q   <= S_WAITIDLE;
            end
          end
          S_WAITIDLE: begin
            if (clk_filt_q && dat_sync_q) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-collector bus model, a
// behavioural PS/2 device and a reference of the expected frame content.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 3000;
  localparam int FLT  = 4;
  localparam int HALF = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2clk_oe, ps2data_oe;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy, done, error;
  logic       dev_clk_pull, dev_data_pull;
  logic       ps2clk_line, ps2data_line;

  // Wired-AND bus: either side pulling makes the line low.
  assign ps2clk_line  = ~(ps2clk_oe | dev_clk_pull);
  assign ps2data_line = ~(ps2data_oe | dev_data_pull);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER        (FLT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2clk_in (ps2clk_line),
    .ps2data_in(ps2data_line),
    .ps2clk_oe (ps2clk_oe),
    .ps2data_oe(ps2data_oe),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Odd parity from the frame rule: total count of ones over data+parity is odd.
  function automatic logic exp_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  // Bus monitor, sampled 2 time units after each rising edge.
  int         cyc = 0, done_cnt = 0, done_cyc = 0;
  int         inh_run = 0, inh_last = 0, inh_start_cyc = 0;
  logic       err_at_done = 1'b0;
  logic [1:0] oe_at_done = '0;
  always begin
    @(posedge clk);
    #2;
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc    = cyc;
      err_at_done = error;
      oe_at_done  = {ps2clk_oe, ps2data_oe};
    end
    if (ps2clk_oe) begin
      if (inh_run == 0) inh_start_cyc = cyc;
      inh_run++;
    end else if (inh_run != 0) begin
      inh_last = inh_run;
      inh_run  = 0;
    end
  end

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("error_cleared", 32'(error), 32'd0);
    tx_data = ~d;
  endtask

  // Device side of one frame: waits for the request, clocks 11 edges,
  // records the bit seen after edges 1..10 and answers edge 11 with ack_low.
  // rst_edge != 0 asserts host reset during that edge and abandons the frame.
  task automatic device_frame(input logic ack_low, input bit glitch, input int rst_edge,
                              output logic [10:0] bits, output bit ok);
    int guard = 0;
    ok   = 1'b1;
    bits = '0;
    while (!(ps2clk_line && !ps2data_line)) begin
      @(negedge clk);
      guard++;
      if (guard > INH + 60) begin
        ok = 1'b0;
        return;
      end
    end
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        dev_data_pull = ack_low;
        repeat (HALF / 2) @(negedge clk);
      end
      dev_clk_pull = 1'b1;
      if (k == rst_edge) begin
        repeat (FLT + 6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_lines", 32'({ps2clk_oe, ps2data_oe}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        dev_clk_pull  = 1'b0;
        dev_data_pull = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      repeat (HALF) @(negedge clk);
      if (k <= 10) bits[k] = ps2data_line;
      dev_clk_pull = 1'b0;
      if (glitch && k < 10) begin
        repeat (HALF / 2) @(negedge clk);
        dev_clk_pull = 1'b1;
        @(negedge clk);
        dev_clk_pull = 1'b0;
        repeat (HALF - HALF / 2 - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_data_pull = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int bound, output bit ok);
    int g = 0;
    ok = 1'b1;
    while (done_cnt == prev) begin
      @(negedge clk);
      g++;
      if (g > bound) begin
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic check_frame(input logic [7:0] d, input logic ack_low, input int prev,
                             input logic [10:0] bits, input bit ok);
    bit okd;
    check("request_seen", 32'(ok), 32'd1);
    check("data_bits", 32'(bits[8:1]), 32'(d));
    check("parity_bit", 32'(bits[9]), 32'(exp_parity(d)));
    check("stop_bit", 32'(bits[10]), 32'd1);
    check("inhibit_len", 32'(inh_last), 32'(INH));
    wait_done(prev, 300, okd);
    check("done_seen", 32'(okd), 32'd1);
    repeat (5) @(negedge clk);
    check("done_once", 32'(done_cnt - prev), 32'd1);
    check("error_at_done", 32'(err_at_done), 32'(!ack_low));
    check("lines_at_done", 32'(oe_at_done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("error_held", 32'(error), 32'(!ack_low));
  endtask

  task automatic run_tx(input logic [7:0] d, input logic ack_low, input bit glitch, input bit inject);
    logic [10:0] bits;
    bit          ok;
    int          prev;
    prev = done_cnt;
    start_tx(d);
    fork
      device_frame(ack_low, glitch, 0, bits, ok);
      if (inject) begin
        repeat (60) @(negedge clk);
        tx_data  = d ^ 8'h5A;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    check_frame(d, ack_low, prev, bits, ok);
  endtask

  task automatic timeout_test();
    bit okd;
    int prev;
    prev = done_cnt;
    start_tx(8'h96);
    wait_done(prev, TMO + 200, okd);
    check("tmo_done_seen", 32'(okd), 32'd1);
    check("tmo_latency", 32'(done_cyc - inh_start_cyc), 32'(TMO));
    check("tmo_error", 32'(err_at_done), 32'd1);
    check("tmo_lines", 32'(oe_at_done), 32'd0);
    repeat (5) @(negedge clk);
    check("tmo_done_once", 32'(done_cnt - prev), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_error_held", 32'(error), 32'd1);
  endtask

  task automatic reset_test();
    logic [10:0] bits;
    bit          ok;
    int          prev;
    prev = done_cnt;
    start_tx(8'h4A);  // bit 4 is 0, so data is being pulled low at edge 5
    device_frame(1'b1, 1'b0, 5, bits, ok);
    check("rst_request_seen", 32'(ok), 32'd1);
    repeat (30) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - prev), 32'd0);
    check("rst_idle_lines", 32'({ps2clk_oe, ps2data_oe}), 32'd0);
    run_tx(8'hF4, 1'b1, 1'b0, 1'b0);
  endtask

  // A start presented during the done cycle waits one cycle before acceptance.
  task automatic overlap_test();
    logic [10:0] bits;
    bit          ok;
    int          prev, g;
    prev = done_cnt;
    start_tx(8'h3C);
    fork
      device_frame(1'b0, 1'b0, 0, bits, ok);
      begin
        g = 0;
        while (!done && g < 2000) begin
          @(negedge clk);
          g++;
        end
        check("ovl_done_seen", 32'(done), 32'd1);
        tx_data  = 8'hC3;
        tx_start = 1'b1;
        @(negedge clk);
        check("ovl_start_blocked", 32'(busy), 32'd0);
        @(negedge clk);
        tx_start = 1'b0;
        check("ovl_start_next", 32'(busy), 32'd1);
        tx_data = 8'h00;
      end
    join
    check("ovl_first_frame", 32'(bits[8:1]), 32'h3C);
    check("ovl_first_error", 32'(err_at_done), 32'd1);
    prev = done_cnt;
    device_frame(1'b1, 1'b0, 0, bits, ok);
    check_frame(8'hC3, 1'b1, prev, bits, ok);
  endtask

  initial begin
    reset         = 1'b1;
    tx_start      = 1'b0;
    tx_data       = '0;
    dev_clk_pull  = 1'b0;
    dev_data_pull = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_lines", 32'({ps2clk_oe, ps2data_oe}), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    run_tx(8'hED, 1'b1, 1'b0, 1'b0);
    run_tx(8'h07, 1'b1, 1'b0, 1'b0);
    run_tx(8'h00, 1'b1, 1'b0, 1'b0);
    run_tx(8'hAA, 1'b0, 1'b0, 1'b0);
    timeout_test();
    run_tx(8'hED, 1'b1, 1'b1, 1'b0);
    reset_test();
    overlap_test();
    for (int i = 0; i < 6; i++) begin
      run_tx(8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(400000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

endmodule
